// File: rtl/dynamic_route_demux_if.sv
// rtl/dynamic_route_demux_if.sv - flit stream bundle between the input port and the five-way steering stage
interface dynamic_route_demux_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       out_valid;
    logic [4:0]       out_ready;
    logic [2:0]       out_sel;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_sel
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_sel
    );
endinterface

// File: rtl/dynamic_route_demux.sv
// rtl/dynamic_route_demux.sv - X-then-Y route decode and one-entry steering stage for a node input port
module dynamic_route_demux #(
    parameter int WIDTH = 64,
    parameter int XY_W  = 8,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [XY_W-1:0]         my_loc_x,
    input  logic [XY_W-1:0]         my_loc_y,
    dynamic_route_demux_if.slave    io
);

    localparam logic [2:0] NORTH = 3'd0;
    localparam logic [2:0] EAST  = 3'd1;
    localparam logic [2:0] SOUTH = 3'd2;
    localparam logic [2:0] WEST  = 3'd3;
    localparam logic [2:0] PROC  = 3'd4;

    typedef enum logic {
        HDR  = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [LEN_W-1:0]   rem_q;
    logic [LEN_W-1:0]   rem_d;
    logic [2:0]         route_q;
    logic [2:0]         route_d;

    logic               stage_vld;
    logic [WIDTH-1:0]   data_q;
    logic [2:0]         sel_q;
    logic [4:0]         onehot;

    logic [XY_W-1:0]    dest_x;
    logic [XY_W-1:0]    dest_y;
    logic [LEN_W-1:0]   len;
    logic [2:0]         route;
    logic [2:0]         flit_route;
    logic               drain;
    logic               accept;

    assign dest_x = io.in_data[WIDTH-1 -: XY_W];
    assign dest_y = io.in_data[WIDTH-1-XY_W -: XY_W];
    assign len    = io.in_data[WIDTH-1-2*XY_W -: LEN_W];

    // Dimension-ordered: resolve X fully before Y, local delivery last
    always_comb begin
        if (dest_x > my_loc_x)
            route = EAST;
        else if (dest_x < my_loc_x)
            route = WEST;
        else if (dest_y > my_loc_y)
            route = SOUTH;
        else if (dest_y < my_loc_y)
            route = NORTH;
        else
            route = PROC;
    end

    assign onehot     = stage_vld ? (5'b00001 << sel_q) : 5'b00000;
    assign drain      = |(io.out_ready & onehot);
    assign io.in_ready = !stage_vld || drain;
    assign accept     = io.in_valid && io.in_ready;
    assign flit_route = (state_q == HDR) ? route : route_q;

    assign io.out_data  = data_q;
    assign io.out_valid = onehot;
    assign io.out_sel   = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR;
            rem_q   <= '0;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        route_d = route_q;
        if (accept) begin
            case (state_q)
                HDR: begin
                    route_d = route;
                    if (len != '0) begin
                        state_d = BODY;
                        rem_d   = len;
                    end
                end
                BODY: begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1))
                        state_d = HDR;
                end
                default: state_d = HDR;
            endcase
        end
    end

    // Drain and refill can coincide, so a new accept always wins over clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= 1'b0;
            data_q    <= '0;
            sel_q     <= '0;
        end else if (accept) begin
            stage_vld <= 1'b1;
            data_q    <= io.in_data;
            sel_q     <= flit_route;
        end else if (drain) begin
            stage_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dynamic_route_demux.sv
// tb/tb_dynamic_route_demux.sv - directed self-checking bench for dynamic_route_demux
module tb_dynamic_route_demux;

    logic       clk;
    logic       rst_n;
    logic [7:0] my_loc_x;
    logic [7:0] my_loc_y;
    int         errors;
    int         checks;

    dynamic_route_demux_if #(.WIDTH(64)) bus ();

    dynamic_route_demux #(
        .WIDTH (64),
        .XY_W  (8),
        .LEN_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .my_loc_x (my_loc_x),
        .my_loc_y (my_loc_y),
        .io       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] dx, input logic [7:0] dy,
                                        input logic [7:0] ln, input logic [15:0] tag);
        return {dx, dy, ln, 24'h000000, tag};
    endfunction

    // Body payloads carry dest=(255,255): if mistaken for a header they would go East
    function automatic logic [63:0] body(input logic [15:0] tag);
        return {8'hFF, 8'hFF, 8'h00, 24'h0B0D00, tag};
    endfunction

    task automatic push(input string tag, input logic [63:0] d, input logic [2:0] sel);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(5'b00001 << sel));
        check({tag, "_sel"}, 64'(bus.out_sel), 64'(sel));
        check({tag, "_data"}, bus.out_data, d);
    endtask

    task automatic idle(input string tag);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(posedge clk);
        #1;
        check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        my_loc_x      = 8'd2;
        my_loc_y      = 8'd2;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 5'h1F;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_sel", 64'(bus.out_sel), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single-flit packet heading East
        push("t1_hdr", hdr(8'd5, 8'd1, 8'd0, 16'h0001), 3'd1);
        check("t1_onehot", 64'(bus.out_valid), 64'h02);
        idle("t1");

        // Local packet of 3 bodies; tile coordinate change mid-packet must not reroute bodies
        push("t2_hdr", hdr(8'd2, 8'd2, 8'd3, 16'h0002), 3'd4);
        check("t2_onehot", 64'(bus.out_valid), 64'h10);
        my_loc_x = 8'd9;
        my_loc_y = 8'd9;
        push("t2_b1", body(16'h0021), 3'd4);
        push("t2_b2", body(16'h0022), 3'd4);
        push("t2_b3", body(16'h0023), 3'd4);
        push("t2_next_hdr", hdr(8'd2, 8'd2, 8'd0, 16'h0024), 3'd3);
        my_loc_x = 8'd2;
        my_loc_y = 8'd2;
        idle("t2");

        // Back-to-back packets: West, West, South with no bubble
        push("t3_hdr_a", hdr(8'd0, 8'd2, 8'd1, 16'h0031), 3'd3);
        push("t3_b1", body(16'h0032), 3'd3);
        push("t3_hdr_b", hdr(8'd2, 8'd4, 8'd0, 16'h0033), 3'd2);
        idle("t3");

        // Backpressure on West while East's ready is high
        bus.out_ready = 5'b10111;
        push("t4_hdr", hdr(8'd0, 8'd5, 8'd2, 16'h0041), 3'd3);
        bus.in_data  = body(16'h0042);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_stall_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
            check("t4_stall_data", bus.out_data, hdr(8'd0, 8'd5, 8'd2, 16'h0041));
            check("t4_stall_valid", 64'(bus.out_valid), 64'h08);
        end
        bus.out_ready = 5'h1F;
        push("t4_b1", body(16'h0042), 3'd3);
        push("t4_b2", body(16'h0043), 3'd3);
        idle("t4");

        // Maximum length: 255 bodies stay North, then a header is decoded again
        push("t5_hdr", hdr(8'd2, 8'd0, 8'd255, 16'h0050), 3'd0);
        for (int i = 1; i <= 255; i++)
            push("t5_body", body(16'(i)), 3'd0);
        push("t5_next_hdr", hdr(8'd5, 8'd2, 8'd0, 16'h0051), 3'd1);
        idle("t5");

        // Asynchronous reset mid-packet
        push("t6_hdr", hdr(8'd0, 8'd2, 8'd4, 16'h0061), 3'd3);
        push("t6_b1", body(16'h0062), 3'd3);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_data", bus.out_data, 64'd0);
        check("t6_rst_sel", 64'(bus.out_sel), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push("t6_new_hdr", hdr(8'd2, 8'd0, 8'd0, 16'h0063), 3'd0);
        check("t6_north", 64'(bus.out_valid), 64'h01);
        idle("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
